// File: rtl/picorv32_mem_arbiter.sv
// Shares one PicoRV32 native memory port between two requesters, one whole transfer at a time.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort transfers the target never completes.
module picorv32_mem_arbiter #(
  parameter int unsigned PRIORITY_MODE  = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,

  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,

  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,

  output logic [1:0]  arb_grant,
  output logic        arb_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        last_grant;    // port served most recently: 0 = port 0, 1 = port 1
  logic        win_port;
  logic        grant_fire;
  logic        finish;
  logic        release_bus;
  logic        expire;
  logic [31:0] finish_rdata;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    win_port = 1'b0;
    if (m0_mem_valid && m1_mem_valid) begin
      win_port = (PRIORITY_MODE == 1) ? 1'b0 : ~last_grant;
    end else if (m1_mem_valid) begin
      win_port = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (m0_mem_valid || m1_mem_valid) state_next = S_BUSY;
      S_BUSY:  if (mem_ready || expire)          state_next = S_DONE;
      // The adapter only releases ready after valid falls, so wait for it here.
      S_DONE:  if (!mem_ready)                   state_next = S_IDLE;
      default:                                   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    grant_fire   = (state == S_IDLE) && (m0_mem_valid || m1_mem_valid);
    finish       = (state == S_BUSY) && (mem_ready || expire);
    release_bus  = (state == S_DONE) && !mem_ready;
    finish_rdata = mem_ready ? mem_rdata : TIMEOUT_RDATA;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid    <= 1'b0;
      mem_instr    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      m0_mem_ready <= 1'b0;
      m1_mem_ready <= 1'b0;
      m0_mem_rdata <= '0;
      m1_mem_rdata <= '0;
      arb_grant    <= 2'b00;
      last_grant   <= 1'b1;
    end else begin
      m0_mem_ready <= 1'b0;
      m1_mem_ready <= 1'b0;

      // The winner's request is copied once; later requester changes are ignored.
      if (grant_fire) begin
        mem_valid  <= 1'b1;
        mem_instr  <= win_port ? m1_mem_instr : m0_mem_instr;
        mem_addr   <= win_port ? m1_mem_addr  : m0_mem_addr;
        mem_wdata  <= win_port ? m1_mem_wdata : m0_mem_wdata;
        mem_wstrb  <= win_port ? m1_mem_wstrb : m0_mem_wstrb;
        arb_grant  <= win_port ? 2'b10 : 2'b01;
        last_grant <= win_port;
      end

      if (finish) begin
        mem_valid <= 1'b0;
        if (arb_grant[0]) begin
          m0_mem_ready <= 1'b1;
          m0_mem_rdata <= finish_rdata;
        end
        if (arb_grant[1]) begin
          m1_mem_ready <= 1'b1;
          m1_mem_rdata <= finish_rdata;
        end
      end

      if (release_bus) begin
        arb_grant <= 2'b00;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  // Counts BUSY cycles of the current transfer; a same-cycle mem_ready beats expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt      <= '0;
      arb_timeout <= 1'b0;
    end else begin
      arb_timeout <= expire;
      if (grant_fire) begin
        wd_cnt <= '0;
      end else if (state == S_BUSY) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  assign expire = (state == S_BUSY) && !mem_ready && (wd_cnt == WD_LAST);
`else
  // Without the watchdog a transfer waits for the target indefinitely; TIMEOUT_CYCLES has no effect.
  assign expire      = (TIMEOUT_CYCLES == 0) & 1'b0;
  assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Randomized bench for picorv32_mem_arbiter: one round-robin and one fixed-priority instance,
// each checked cycle by cycle against a transaction-level ownership model.
module tb_picorv32_mem_arbiter;

  localparam int unsigned TO_CYCLES = 8;
  localparam logic [31:0] TO_RDATA  = 32'hDEAD_BEEF;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index [d] selects the instance: 0 = round-robin, 1 = fixed priority.
  logic        reset       [2];
  logic        m_valid     [2][2];
  logic        m_instr     [2][2];
  logic [31:0] m_addr      [2][2];
  logic [31:0] m_wdata     [2][2];
  logic [3:0]  m_wstrb     [2][2];
  logic        m_ready     [2][2];
  logic [31:0] m_rdata     [2][2];
  logic        mem_valid   [2];
  logic        mem_instr   [2];
  logic [31:0] mem_addr    [2];
  logic [31:0] mem_wdata   [2];
  logic [3:0]  mem_wstrb   [2];
  logic        mem_ready   [2];
  logic [31:0] mem_rdata   [2];
  logic [1:0]  arb_grant   [2];
  logic        arb_timeout [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    picorv32_mem_arbiter #(
      .PRIORITY_MODE (g),
      .TIMEOUT_CYCLES(TO_CYCLES),
      .TIMEOUT_RDATA (TO_RDATA)
    ) u_dut (
      .clk         (clk),
      .reset       (reset[g]),
      .m0_mem_valid(m_valid[g][0]),
      .m0_mem_instr(m_instr[g][0]),
      .m0_mem_addr (m_addr[g][0]),
      .m0_mem_wdata(m_wdata[g][0]),
      .m0_mem_wstrb(m_wstrb[g][0]),
      .m0_mem_ready(m_ready[g][0]),
      .m0_mem_rdata(m_rdata[g][0]),
      .m1_mem_valid(m_valid[g][1]),
      .m1_mem_instr(m_instr[g][1]),
      .m1_mem_addr (m_addr[g][1]),
      .m1_mem_wdata(m_wdata[g][1]),
      .m1_mem_wstrb(m_wstrb[g][1]),
      .m1_mem_ready(m_ready[g][1]),
      .m1_mem_rdata(m_rdata[g][1]),
      .mem_valid   (mem_valid[g]),
      .mem_instr   (mem_instr[g]),
      .mem_addr    (mem_addr[g]),
      .mem_wdata   (mem_wdata[g]),
      .mem_wstrb   (mem_wstrb[g]),
      .mem_ready   (mem_ready[g]),
      .mem_rdata   (mem_rdata[g]),
      .arb_grant   (arb_grant[g]),
      .arb_timeout (arb_timeout[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cur     = 0;

  // Ownership model: owner < 0 means the bus is free; draining means the
  // transfer has ended and the bus waits for the target to drop ready.
  int          owner;
  bit          draining;
  int          last_winner;
  int          busy_cycles;
  bit          exp_valid;
  bit          exp_instr;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_wstrb;
  logic [1:0]  exp_grant;
  bit          exp_timeout;
  bit          exp_ready [2];
  logic [31:0] exp_rdata [2];

  bit resp_armed;
  int resp_lat;
  int resp_sticky;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (mode %0d, cycle %0d)", tag, got, exp, cur, cyc);
    end
  endtask

  // Applies the transfer rules to the inputs that the DUT sampled on the last edge.
  task automatic model_step(input int d);
    int win;
    exp_ready[0] = 1'b0;
    exp_ready[1] = 1'b0;
    exp_timeout  = 1'b0;
    if (reset[d]) begin
      owner        = -1;
      draining     = 1'b0;
      last_winner  = 1;
      busy_cycles  = 0;
      exp_valid    = 1'b0;
      exp_instr    = 1'b0;
      exp_addr     = '0;
      exp_wdata    = '0;
      exp_wstrb    = '0;
      exp_grant    = 2'b00;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
    end else if (owner < 0) begin
      if (m_valid[d][0] || m_valid[d][1]) begin
        if (m_valid[d][0] && m_valid[d][1]) win = (d == 1) ? 0 : 1 - last_winner;
        else                                win = m_valid[d][0] ? 0 : 1;
        owner       = win;
        last_winner = win;
        busy_cycles = 0;
        exp_valid   = 1'b1;
        exp_grant   = (win == 0) ? 2'b01 : 2'b10;
        exp_instr   = m_instr[d][win];
        exp_addr    = m_addr[d][win];
        exp_wdata   = m_wdata[d][win];
        exp_wstrb   = m_wstrb[d][win];
      end
    end else if (!draining) begin
      if (mem_ready[d]) begin
        exp_rdata[owner] = mem_rdata[d];
        exp_ready[owner] = 1'b1;
        exp_valid        = 1'b0;
        draining         = 1'b1;
      end else if (TIMEOUT_ON && busy_cycles == int'(TO_CYCLES) - 1) begin
        exp_rdata[owner] = TO_RDATA;
        exp_ready[owner] = 1'b1;
        exp_timeout      = 1'b1;
        exp_valid        = 1'b0;
        draining         = 1'b1;
      end else begin
        busy_cycles++;
      end
    end else if (!mem_ready[d]) begin
      owner     = -1;
      draining  = 1'b0;
      exp_grant = 2'b00;
    end
  endtask

  task automatic compare(input int d);
    check("mem_valid",   32'(mem_valid[d]),   32'(exp_valid));
    check("arb_grant",   32'(arb_grant[d]),   32'(exp_grant));
    check("arb_timeout", 32'(arb_timeout[d]), 32'(exp_timeout));
    check("m0_ready",    32'(m_ready[d][0]),  32'(exp_ready[0]));
    check("m1_ready",    32'(m_ready[d][1]),  32'(exp_ready[1]));
    check("m0_rdata",    m_rdata[d][0],       exp_rdata[0]);
    check("m1_rdata",    m_rdata[d][1],       exp_rdata[1]);
    if (exp_valid || reset[d]) begin
      check("mem_instr", 32'(mem_instr[d]), 32'(exp_instr));
      check("mem_addr",  mem_addr[d],       exp_addr);
      check("mem_wdata", mem_wdata[d],      exp_wdata);
      check("mem_wstrb", 32'(mem_wstrb[d]), 32'(exp_wstrb));
    end
  endtask

  task automatic new_request(input int d, input int p);
    m_valid[d][p] = 1'b1;
    m_instr[d][p] = 1'($urandom_range(0, 1));
    m_addr[d][p]  = $urandom;
    m_wdata[d][p] = $urandom;
    m_wstrb[d][p] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
  endtask

  task automatic drive(input int d, input int unsigned start_pct, input int unsigned cont_pct,
                       input int unsigned drop_pct);
    for (int p = 0; p < 2; p++) begin
      if (m_ready[d][p]) begin
        if ($urandom_range(0, 99) < cont_pct) new_request(d, p);
        else                                  m_valid[d][p] = 1'b0;
      end else if (!m_valid[d][p]) begin
        if ($urandom_range(0, 99) < start_pct) new_request(d, p);
      end else if (owner == p && !draining) begin
        // Granted requester scribbles on its inputs; the captured copy must stay on the bus.
        m_instr[d][p] = ~m_instr[d][p];
        m_addr[d][p]  = $urandom;
        m_wdata[d][p] = $urandom;
        m_wstrb[d][p] = 4'($urandom_range(0, 15));
      end else if (owner != p && $urandom_range(0, 99) < drop_pct) begin
        m_valid[d][p] = 1'b0;
      end
    end

    // Target: random latency, then a ready that lingers 0..3 cycles after valid falls.
    if (mem_ready[d]) begin
      if (!mem_valid[d]) begin
        if (resp_sticky == 0) mem_ready[d] = 1'b0;
        else                  resp_sticky--;
      end
    end else if (mem_valid[d]) begin
      if (!resp_armed) begin
        resp_armed = 1'b1;
        resp_lat   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 3));
      end
      if (resp_lat == 0) begin
        mem_ready[d] = 1'b1;
        resp_armed   = 1'b0;
        resp_sticky  = int'($urandom_range(0, 3));
      end else begin
        resp_lat--;
      end
    end else begin
      resp_armed = 1'b0;
    end
    mem_rdata[d] = $urandom;

    reset[d] = 1'b0;
    if (owner >= 0 && !draining && $urandom_range(0, 59) == 0) reset[d] = 1'b1;
    if ($urandom_range(0, 499) == 0)                           reset[d] = 1'b1;
    if (reset[d]) begin
      mem_ready[d] = 1'b0;
      resp_armed   = 1'b0;
    end
  endtask

  task automatic run_phase(input int d, input int n, input int unsigned start_pct,
                           input int unsigned cont_pct, input int unsigned drop_pct);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      model_step(d);
      compare(d);
      drive(d, start_pct, cont_pct, drop_pct);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d]     = 1'b1;
      mem_ready[d] = 1'b0;
      mem_rdata[d] = '0;
      for (int p = 0; p < 2; p++) begin
        m_valid[d][p] = 1'b0;
        m_instr[d][p] = 1'b0;
        m_addr[d][p]  = '0;
        m_wdata[d][p] = '0;
        m_wstrb[d][p] = '0;
      end
    end
    resp_armed  = 1'b0;
    resp_lat    = 0;
    resp_sticky = 0;

    for (int d = 0; d < 2; d++) begin
      cur        = d;
      resp_armed = 1'b0;
      for (int i = 0; i < 2; i++) begin
        @(posedge clk);
        #1;
        cyc++;
        model_step(d);
        compare(d);
      end
      reset[d] = 1'b0;
      run_phase(d, 200, 100, 100, 0);
      run_phase(d, 1500, 35, 30, 3);
      reset[d]      = 1'b1;
      mem_ready[d]  = 1'b0;
      m_valid[d][0] = 1'b0;
      m_valid[d][1] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/picorv32_mem_arbiter.md
Name: picorv32_mem_arbiter

Overview:
Two-port arbiter sharing one PicoRV32 native memory interface between two requesters, e.g. CPU core and debug/DMA master. The single downstream port feeds the PicoRV32-to-FreeAHB adapter. It runs round-robin or fixed-priority arbitration and holds each grant for the whole transfer. Transfers are never interleaved.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 always wins ties)
TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles (used only with MEM_ARB_TIMEOUT_EN)
TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on timeout (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
m0_mem_valid / m1_mem_valid  in  1  requester transfer request; held until its ready
m0_mem_instr / m1_mem_instr  in  1  instruction-fetch qualifier
m0_mem_addr / m1_mem_addr  in  32  byte address
m0_mem_wdata / m1_mem_wdata  in  32  write data
m0_mem_wstrb / m1_mem_wstrb  in  4  byte strobes; 0 = read
m0_mem_ready / m1_mem_ready  out  1  one-cycle completion pulse
m0_mem_rdata / m1_mem_rdata  out  32  registered read data; valid with ready
mem_valid  out  1  downstream request
mem_instr  out  1  downstream qualifier
mem_addr  out  32  downstream address
mem_wdata  out  32  downstream write data
mem_wstrb  out  4  downstream strobes
mem_ready  in  1  downstream completion; may stay high until mem_valid drops
mem_rdata  in  32  downstream read data
arb_grant  out  2  one-hot owner: 01 = port 0, 10 = port 1, 00 = none
arb_timeout  out  1  one-cycle pulse on watchdog expiry (tied 0 without the feature)

Behaviour:
- Reset values: every output is 0, state = IDLE, last_grant = port 1 so port 0 wins the first round-robin tie, watchdog = 0.
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high. Reset mid-transfer drops mem_valid on the next edge and returns to IDLE. No ready pulse is issued for the aborted transfer.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Sample m0/m1_mem_valid.
  - Winner: if only one port requests, it wins. If both request, PRIORITY_MODE=0 picks the port not in last_grant; PRIORITY_MODE=1 picks port 0.
  - On the next edge: register the winner's instr/addr/wdata/wstrb onto the downstream outputs, set mem_valid=1, set arb_grant, update last_grant, go to BUSY. Latency from request to downstream valid is 1 cycle.
  - With no request, stay in IDLE with mem_valid=0.
- BUSY:
  - Hold the downstream outputs stable. Requester input changes are ignored; the captured copy is used.
  - On mem_ready=1: capture mem_rdata into the granted port's rdata, pulse that port's ready for exactly 1 cycle, drop mem_valid, go to DONE.
  - Latency from downstream ready to requester ready is 1 cycle.
- DONE:
  - Ignore mem_ready while it is still high, since the adapter clears ready only after valid falls.
  - When mem_ready=0: arb_grant=00, go to IDLE.
  - Minimum 1 cycle in DONE. Back-to-back transfers are therefore at least 3 cycles apart at the downstream port.
- Non-granted port: its ready stays 0 and its request stays pending. In round-robin mode neither port can be granted twice in a row while the other is waiting.
- rdata: each port's rdata holds its last captured value until that port's next completion. Writes also capture mem_rdata, which is don't-care.
- A requester dropping valid while not granted simply withdraws its request. Dropping valid while granted is a protocol violation; the transfer still completes.

Optional Feature:
MEM_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entering BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES-1 without mem_ready: the granted port gets ready with rdata = TIMEOUT_RDATA, arb_timeout pulses for 1 cycle, mem_valid drops, and the FSM goes to DONE.
  - mem_ready arriving in the same cycle as expiry wins: a normal completion, no timeout pulse.
- Undefined: no counter is built, arb_timeout is tied 0, and the arbiter waits in BUSY indefinitely.

Test Plan:
- Single read: m0 read 0x0000_0100; downstream ready 3 cycles after mem_valid with rdata 0x1234_5678 -> m0_mem_ready pulses 1 cycle with rdata 0x1234_5678; arb_grant 01 then 00; m1_mem_ready stays 0.
- Simultaneous requests, PRIORITY_MODE=0: both ports request continuously for 4 transfers -> grant order 0,1,0,1 and mem_addr alternates between the two ports' addresses.
- Simultaneous requests, PRIORITY_MODE=1: both ports request for 3 transfers -> port 0 is served every time; port 1 is served only after port 0 drops valid.
- Sticky downstream ready: mem_ready stays high for 2 cycles after mem_valid falls, with m1 pending -> no new mem_valid until mem_ready=0; no spurious second ready pulse.
- Reset mid-transfer: assert reset in BUSY for a port-1 write, wstrb 4'b0011 -> next edge mem_valid=0, arb_grant=00, no m1 ready pulse; the next port-0 request is granted first.
- Timeout with MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: mem_ready held 0 -> port ready on the 8th BUSY cycle with rdata 0xDEAD_BEEF and arb_timeout pulsing once; mem_ready asserted on the expiry cycle instead -> normal rdata and no timeout pulse.
